// File: rtl/row_perm_table_gen_if.sv
// Control and SRAM strobe/address signals of the row-permutation table generator.
// The bidirectional SRAM data bus stays a plain inout on the module.
interface row_perm_table_gen_if;
    logic        start;
    logic [15:0] key;
    logic        busy;
    logic        done;
    logic        led;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    modport master (
        output start, key,
        input  busy, done, led, sram_addr, sram_we_n, sram_oe_n,
               sram_ce_n, sram_lb_n, sram_ub_n
    );

    modport slave (
        input  start, key,
        output busy, done, led, sram_addr, sram_we_n, sram_oe_n,
               sram_ce_n, sram_lb_n, sram_ub_n
    );
endinterface

// File: rtl/row_perm_table_gen.sv
// Builds a row permutation 1..N_ROWS by LFSR rejection sampling against a used-row
// bitmap and writes each entry to async SRAM at TABLE_BASE+k.
module row_perm_table_gen #(
    parameter int unsigned N_ROWS     = 384,
    parameter int unsigned IDX_BITS   = 9,
    parameter logic [17:0] TABLE_BASE = 18'hC100,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic [15:0] LFSR_TAPS  = 16'hB400
) (
    input  logic               clk,
    input  logic               reset,
    row_perm_table_gen_if.slave bus,
    inout  wire  [15:0]        sram_data
);

    localparam int unsigned CAND_BITS = IDX_BITS + 1;
    localparam int unsigned MAP_SIZE  = 2 ** IDX_BITS;
    localparam logic [15:0] CLR_LAST  = 16'(MAP_SIZE - 1);
    localparam logic [15:0] ROWS_W    = 16'(N_ROWS);
    localparam logic [CAND_BITS-1:0] ROWS_C   = CAND_BITS'(N_ROWS);
    localparam logic [CAND_BITS-1:0] CAND_ONE = CAND_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_STEP, S_CHECK, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
    } state_t;

    state_t                state;
    logic [15:0]           lfsr;
    logic [15:0]           count;
    logic [15:0]           clr;
    logic [CAND_BITS-1:0]  cand;
    logic [MAP_SIZE-1:0]   used;
    logic [17:0]           addr;
    logic [15:0]           data;
    logic                  drive;
    logic                  we_n;
    logic                  busy;
    logic                  done;

    logic [15:0]           lfsr_next;
    logic [IDX_BITS-1:0]   cand_idx;
    logic                  accept;
    logic [15:0]           count_next;

    // Galois step, bitmap slot of the current candidate, and the acceptance test.
    always_comb begin
        lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        cand_idx   = IDX_BITS'(cand - CAND_ONE);
        accept     = (cand >= CAND_ONE) && (cand <= ROWS_C) && !used[cand_idx];
        count_next = count + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            lfsr  <= SEED;
            count <= '0;
            clr   <= '0;
            cand  <= '0;
            addr  <= TABLE_BASE;
            data  <= '0;
            drive <= 1'b0;
            we_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        lfsr  <= (bus.key != 16'd0) ? bus.key : SEED;
                        count <= '0;
                        clr   <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr <= clr + 16'd1;
                    if (clr == CLR_LAST) state <= S_STEP;
                end
                S_STEP: begin
                    lfsr  <= lfsr_next;
                    cand  <= CAND_BITS'(lfsr_next[IDX_BITS-1:0]) + CAND_ONE;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (accept) begin
                        addr  <= TABLE_BASE + 18'(count);
                        data  <= 16'(cand);
                        drive <= 1'b1;
                        we_n  <= 1'b1;
                        state <= S_WR_SETUP;
                    end else begin
                        state <= S_STEP;
                    end
                end
                S_WR_SETUP: begin
                    we_n  <= 1'b0;
                    state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    we_n  <= 1'b1;
                    state <= S_WR_HOLD;
                end
                S_WR_HOLD: begin
                    drive <= 1'b0;
                    count <= count_next;
                    if (count_next == ROWS_W) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_STEP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bitmap needs no reset: CLEAR rebuilds it at the start of every run.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            used[clr[IDX_BITS-1:0]] <= 1'b0;
        end else if (state == S_CHECK && accept) begin
            used[cand_idx] <= 1'b1;
        end
    end

    assign sram_data     = drive ? data : 16'hzzzz;
    assign bus.sram_addr = addr;
    assign bus.sram_we_n = we_n;
    assign bus.sram_oe_n = 1'b1;
    assign bus.sram_ce_n = 1'b0;
    assign bus.sram_lb_n = 1'b0;
    assign bus.sram_ub_n = 1'b0;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.led       = done;

endmodule

// File: tb/tb_row_perm_table_gen.sv
// Directed-sequence bench for row_perm_table_gen: full-size and 4-row builds compared
// against a plain LFSR rejection-sampling model, plus a bus-timing monitor.
module tb_row_perm_table_gen;

    localparam logic [15:0] SEED    = 16'hACE1;
    localparam logic [15:0] TAPS    = 16'hB400;
    localparam logic [17:0] BASE    = 18'hC100;
    localparam int          TIMEOUT = 40000;

    logic clk = 1'b0;
    logic reset;
    tri1 [15:0] sram_data;
    tri1 [15:0] sram_data_s;

    row_perm_table_gen_if bus();
    row_perm_table_gen_if bus_s();

    row_perm_table_gen dut (
        .clk(clk), .reset(reset), .bus(bus), .sram_data(sram_data)
    );

    row_perm_table_gen #(.N_ROWS(4), .IDX_BITS(2)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s), .sram_data(sram_data_s)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference: straight rejection sampling over the LFSR sequence.
    int exp_q[$];
    function automatic void build_model(input logic [15:0] k, input int n, input int bits);
        logic [15:0] s;
        bit          seen[1024];
        int          c;
        int          guard;
        foreach (seen[i]) seen[i] = 1'b0;
        exp_q.delete();
        s     = (k != 16'd0) ? k : SEED;
        guard = 0;
        while (exp_q.size() < n && guard < 2000000) begin
            s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
            c = (int'(s) & ((1 << bits) - 1)) + 1;
            if (c <= n && !seen[c-1]) begin
                seen[c-1] = 1'b1;
                exp_q.push_back(c);
            end
            guard++;
        end
    endfunction

    // Write capture and bus-timing monitor for the full-size instance.
    logic [17:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic        mon_en = 1'b0;
    logic        p1_we = 1'b1, p2_we = 1'b1, c_we;
    logic [17:0] p1_a = '0, p2_a = '0, c_a;
    logic [15:0] p1_d = 16'hFFFF, p2_d = 16'hFFFF, c_d;

    always @(negedge clk) begin
        if (!mon_en) begin
            p1_we = 1'b1; p2_we = 1'b1;
            p1_d  = 16'hFFFF; p2_d = 16'hFFFF;
        end else begin
            c_we = bus.sram_we_n;
            c_a  = bus.sram_addr;
            c_d  = sram_data;
            if (c_we === 1'b0) begin
                wa_q.push_back(c_a);
                wd_q.push_back(c_d);
            end
            if (p1_we === 1'b0) begin
                check("we_pulse_width", {30'd0, p2_we, c_we}, 32'd3);
                check("addr_stable", 32'((p2_a === p1_a) && (c_a === p1_a)), 32'd1);
                check("data_stable", 32'((p2_d === p1_d) && (c_d === p1_d)), 32'd1);
                check("data_driven", 32'(p1_d !== 16'hFFFF), 32'd1);
            end else if (p2_we === 1'b1 && c_we === 1'b1) begin
                check("bus_released", 32'(p1_d), 32'hFFFF);
            end
            p2_we = p1_we; p2_a = p1_a; p2_d = p1_d;
            p1_we = c_we;  p1_a = c_a;  p1_d = c_d;
        end
    end

    logic [17:0] sa_q[$];
    logic [15:0] sd_q[$];
    always @(negedge clk) begin
        if (!reset && bus_s.sram_we_n === 1'b0) begin
            sa_q.push_back(bus_s.sram_addr);
            sd_q.push_back(sram_data_s);
        end
    end

    task automatic check_table(input string tag, input int n, input int bits, input logic [15:0] k);
        bit seen[1024];
        int distinct;
        build_model(k, n, bits);
        check({tag, "_count"}, 32'(wa_q.size()), 32'(n));
        foreach (seen[i]) seen[i] = 1'b0;
        distinct = 0;
        for (int i = 0; i < wa_q.size() && i < n; i++) begin
            check($sformatf("%s_addr[%0d]", tag, i), 32'(wa_q[i]), 32'(BASE + 18'(i)));
            check($sformatf("%s_data[%0d]", tag, i), 32'(wd_q[i]), 32'(exp_q[i]));
            if (wd_q[i] >= 1 && wd_q[i] <= 16'(n) && !seen[wd_q[i]-1]) begin
                seen[wd_q[i]-1] = 1'b1;
                distinct++;
            end
        end
        check({tag, "_perm"}, 32'(distinct), 32'(n));
    endtask

    task automatic run_big(input logic [15:0] k, input int pulse_at, input logic [15:0] junk);
        int cyc;
        wa_q.delete();
        wd_q.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = k;
        @(negedge clk);
        bus.start = 1'b0;
        bus.key   = 16'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("done_cleared", 32'(bus.done), 32'd0);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (cyc == pulse_at) begin
                bus.start = 1'b1;
                bus.key   = junk;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("run_in_budget", 32'(cyc < TIMEOUT), 32'd1);
        check("busy_at_end", 32'(bus.busy), 32'd0);
        check("led_at_end", 32'(bus.led), 32'd1);
        check_table("full", 384, 9, k);
    endtask

    logic [15:0] tab0[$];
    logic [15:0] tab1234[$];
    logic [15:0] rkey;
    int          diffs;
    int          cyc;

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.key     = '0;
        bus_s.start = 1'b0;
        bus_s.key   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_led", 32'(bus.led), 32'd0);
        check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("rst_addr", 32'(bus.sram_addr), 32'(BASE));
        check("rst_data_z", 32'(sram_data), 32'hFFFF);
        check("rst_ties", {27'd0, bus.sram_oe_n, bus.sram_ce_n, bus.sram_lb_n,
                           bus.sram_ub_n, bus_s.sram_we_n}, 32'h11);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Reset arriving during the WR_PULSE of entry 100.
        rkey = 16'($urandom_range(1, 65535));
        wa_q.delete();
        wd_q.delete();
        bus.start = 1'b1;
        bus.key   = rkey;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.sram_we_n === 1'b0 && bus.sram_addr === BASE + 18'd100) && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_entry_100", 32'(cyc < TIMEOUT), 32'd1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("midrst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("midrst_data_z", 32'(sram_data), 32'hFFFF);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_addr", 32'(bus.sram_addr), 32'(BASE));
        @(negedge clk);
        check("partial_count", 32'(wa_q.size()), 32'd101);
        build_model(rkey, 384, 9);
        for (int i = 0; i < wd_q.size() && i < 101; i++)
            check($sformatf("partial_data[%0d]", i), 32'(wd_q[i]), 32'(exp_q[i]));
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idle_busy", 32'(bus.busy), 32'd0);
        check("post_rst_no_writes", 32'(wa_q.size()), 32'd101);
        mon_en = 1'b1;

        // key=0 full build, then a rerun with an ignored start pulse 50 cycles in.
        run_big(16'h0000, -1, 16'h0);
        tab0 = wd_q;
        run_big(16'h0000, 50, 16'($urandom_range(1, 65535)));
        diffs = 0;
        for (int i = 0; i < wd_q.size() && i < tab0.size(); i++)
            if (wd_q[i] !== tab0[i]) diffs++;
        check("ignored_start_diffs", 32'(diffs), 32'd0);

        // Determinism and key sensitivity.
        run_big(16'h1234, -1, 16'h0);
        tab1234 = wd_q;
        run_big(16'h1234, -1, 16'h0);
        diffs = 0;
        for (int i = 0; i < wd_q.size() && i < tab1234.size(); i++)
            if (wd_q[i] !== tab1234[i]) diffs++;
        check("repeat_key_diffs", 32'(diffs), 32'd0);
        run_big(16'h1235, -1, 16'h0);
        diffs = 0;
        for (int i = 0; i < wd_q.size() && i < tab1234.size(); i++)
            if (wd_q[i] !== tab1234[i]) diffs++;
        check("other_key_differs", 32'(diffs != 0), 32'd1);

        // Small build: 4 rows, 2-bit candidates.
        sa_q.delete();
        sd_q.delete();
        @(negedge clk);
        bus_s.start = 1'b1;
        bus_s.key   = 16'h0001;
        @(negedge clk);
        bus_s.start = 1'b0;
        cyc = 0;
        while (bus_s.done !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("small_in_budget", 32'(cyc < 4000), 32'd1);
        check("small_led", 32'(bus_s.led), 32'd1);
        build_model(16'h0001, 4, 2);
        check("small_count", 32'(sa_q.size()), 32'd4);
        for (int i = 0; i < sa_q.size() && i < 4; i++) begin
            check($sformatf("small_addr[%0d]", i), 32'(sa_q[i]), 32'(BASE + 18'(i)));
            check($sformatf("small_data[%0d]", i), 32'(sd_q[i]), 32'(exp_q[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
